soft_body_integrator: RTL and testbench



---
 rtl/soft_body_pkg.sv | 39 +++
 rtl/euler_lane.sv | 111 +++++++++++
 rtl/soft_body_integrator.sv | 161 ++++++++++++++++
 tb/tb_soft_body_integrator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/soft_body_pkg.sv
// Shared types and helpers for the soft-body integrator: FSM states, saturating resize, flat node index.
// Optional damping is selected with SOFT_BODY_DAMPING_EN (see euler_lane).
package soft_body_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } sb_state_t;

    // Clamp a wide signed value into the range of a signed field of the given width.
    function automatic logic signed [63:0] sat_width(input logic signed [63:0] value, input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

    function automatic logic signed [63:0] sat_pos(input logic signed [63:0] value, input int pos_size);
        return sat_width(value, pos_size);
    endfunction

    function automatic logic signed [63:0] sat_vel(input logic signed [63:0] value, input int vel_size);
        return sat_width(value, vel_size);
    endfunction

    function automatic int flat_index(input int body, input int node, input int num_nodes);
        return body * num_nodes + node;
    endfunction

endpackage

// File: rtl/euler_lane.sv
// Two-stage semi-implicit Euler datapath for one node: stage 1 updates velocity, stage 2 position.
// With SOFT_BODY_DAMPING_EN defined, enabled nodes get v - (v >>> DAMP_SHIFT) before the position step.
module euler_lane
    import soft_body_pkg::*;
#(
    parameter int POSITION_SIZE = 17,
    parameter int VELOCITY_SIZE = 12,
    parameter int FORCE_SIZE    = 8,
    parameter int DT            = 1,
    parameter int GRAVITY       = -1,
    parameter int MASS_SHIFT    = 0,
    parameter int DAMP_SHIFT    = 4,
    parameter int TAG_W         = 5
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic                            in_valid,
    input  logic                            enable,
    input  logic [TAG_W-1:0]                tag_in,
    input  logic signed [POSITION_SIZE-1:0] pos_x,
    input  logic signed [POSITION_SIZE-1:0] pos_y,
    input  logic signed [VELOCITY_SIZE-1:0] vel_x,
    input  logic signed [VELOCITY_SIZE-1:0] vel_y,
    input  logic signed [FORCE_SIZE-1:0]    force_x,
    input  logic signed [FORCE_SIZE-1:0]    force_y,
    output logic                            s1_valid,
    output logic                            out_valid,
    output logic [TAG_W-1:0]                tag_out,
    output logic signed [POSITION_SIZE-1:0] pos_x_out,
    output logic signed [POSITION_SIZE-1:0] pos_y_out,
    output logic signed [VELOCITY_SIZE-1:0] vel_x_out,
    output logic signed [VELOCITY_SIZE-1:0] vel_y_out
);

    localparam int VW = VELOCITY_SIZE + FORCE_SIZE + 4;
    localparam int PW = POSITION_SIZE + VELOCITY_SIZE + 4;
`ifdef SOFT_BODY_DAMPING_EN
    localparam bit DAMP_ON = 1'b1;
`else
    localparam bit DAMP_ON = 1'b0;
`endif

    logic signed [FORCE_SIZE-1:0]    acc_x, acc_y;
    logic signed [VW-1:0]            vsum_x, vsum_y;
    logic signed [VELOCITY_SIZE-1:0] vsat_x, vsat_y, vnew_x, vnew_y;

    assign acc_x  = force_x >>> MASS_SHIFT;
    assign acc_y  = force_y >>> MASS_SHIFT;
    assign vsum_x = VW'(vel_x) + VW'(acc_x) * VW'(DT);
    assign vsum_y = VW'(vel_y) + (VW'(acc_y) + VW'(GRAVITY)) * VW'(DT);
    assign vsat_x = VELOCITY_SIZE'(sat_vel(64'(vsum_x), VELOCITY_SIZE));
    assign vsat_y = VELOCITY_SIZE'(sat_vel(64'(vsum_y), VELOCITY_SIZE));

    // Masked-off nodes pass their snapshot velocity straight through; damping never touches them.
    assign vnew_x = !enable ? vel_x : (DAMP_ON ? vsat_x - (vsat_x >>> DAMP_SHIFT) : vsat_x);
    assign vnew_y = !enable ? vel_y : (DAMP_ON ? vsat_y - (vsat_y >>> DAMP_SHIFT) : vsat_y);

    logic                            s1_valid_reg, s1_en_reg;
    logic [TAG_W-1:0]                s1_tag_reg;
    logic signed [POSITION_SIZE-1:0] s1_pos_x_reg, s1_pos_y_reg;
    logic signed [VELOCITY_SIZE-1:0] s1_vel_x_reg, s1_vel_y_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_valid_reg <= 1'b0;
            s1_en_reg    <= 1'b0;
            s1_tag_reg   <= '0;
            s1_pos_x_reg <= '0;
            s1_pos_y_reg <= '0;
            s1_vel_x_reg <= '0;
            s1_vel_y_reg <= '0;
        end else begin
            s1_valid_reg <= in_valid;
            s1_en_reg    <= enable;
            s1_tag_reg   <= tag_in;
            s1_pos_x_reg <= pos_x;
            s1_pos_y_reg <= pos_y;
            s1_vel_x_reg <= vnew_x;
            s1_vel_y_reg <= vnew_y;
        end
    end

    logic signed [PW-1:0]            psum_x, psum_y;
    logic signed [POSITION_SIZE-1:0] pnew_x, pnew_y;

    assign psum_x = PW'(s1_pos_x_reg) + PW'(s1_vel_x_reg) * PW'(DT);
    assign psum_y = PW'(s1_pos_y_reg) + PW'(s1_vel_y_reg) * PW'(DT);
    assign pnew_x = s1_en_reg ? POSITION_SIZE'(sat_pos(64'(psum_x), POSITION_SIZE)) : s1_pos_x_reg;
    assign pnew_y = s1_en_reg ? POSITION_SIZE'(sat_pos(64'(psum_y), POSITION_SIZE)) : s1_pos_y_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            out_valid <= 1'b0;
            tag_out   <= '0;
            pos_x_out <= '0;
            pos_y_out <= '0;
            vel_x_out <= '0;
            vel_y_out <= '0;
        end else begin
            out_valid <= s1_valid_reg;
            tag_out   <= s1_tag_reg;
            pos_x_out <= pnew_x;
            pos_y_out <= pnew_y;
            vel_x_out <= s1_vel_x_reg;
            vel_y_out <= s1_vel_y_reg;
        end
    end

    assign s1_valid = s1_valid_reg;

endmodule

// File: rtl/soft_body_integrator.sv
// Multi-body soft-body integrator: snapshots all bodies on begin_in and streams updated nodes one per cycle.
// Optional per-node damping is compiled in with SOFT_BODY_DAMPING_EN.
module soft_body_integrator
    import soft_body_pkg::*;
#(
    parameter int NUM_BODIES    = 2,
    parameter int NUM_NODES     = 4,
    parameter int POSITION_SIZE = 17,
    parameter int VELOCITY_SIZE = 12,
    parameter int FORCE_SIZE    = 8,
    parameter int DT            = 1,
    parameter int GRAVITY       = -1,
    parameter int MASS_SHIFT    = 0,
    parameter int DAMP_SHIFT    = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            begin_in,
    input  logic [NUM_BODIES-1:0]           body_mask,
    input  logic signed [POSITION_SIZE-1:0] nodes_in      [2][NUM_BODIES*NUM_NODES],
    input  logic signed [VELOCITY_SIZE-1:0] velocities_in [2][NUM_BODIES*NUM_NODES],
    input  logic signed [FORCE_SIZE-1:0]    forces_in     [2][NUM_BODIES*NUM_NODES],
    output logic                            busy_out,
    output logic signed [POSITION_SIZE-1:0] node_out_x,
    output logic signed [POSITION_SIZE-1:0] node_out_y,
    output logic signed [VELOCITY_SIZE-1:0] velocity_out_x,
    output logic signed [VELOCITY_SIZE-1:0] velocity_out_y,
    output logic [$clog2(NUM_BODIES):0]     out_body,
    output logic [$clog2(NUM_NODES):0]      out_node,
    output logic                            node_out_valid,
    output logic                            velocity_out_valid,
    output logic                            result_out
);

    localparam int TOTAL = NUM_BODIES * NUM_NODES;
    localparam int BW    = $clog2(NUM_BODIES) + 1;
    localparam int NW    = $clog2(NUM_NODES) + 1;
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    sb_state_t       state_reg, state_next;
    logic [BW-1:0]   body_cnt_reg, body_cnt_next;
    logic [NW-1:0]   node_cnt_reg, node_cnt_next;
    logic            issue_valid, issue_en, snap_load, pipe_busy, lane_valid;
    logic [IW-1:0]   issue_idx;
    logic [BW+NW-1:0] lane_tag;

    logic [NUM_BODIES-1:0]           mask_reg;
    logic signed [POSITION_SIZE-1:0] snap_pos_reg [2][TOTAL];
    logic signed [VELOCITY_SIZE-1:0] snap_vel_reg [2][TOTAL];
    logic signed [FORCE_SIZE-1:0]    snap_frc_reg [2][TOTAL];

    always_ff @(posedge clk_in) begin
        if (snap_load) begin
            mask_reg     <= body_mask;
            snap_pos_reg <= nodes_in;
            snap_vel_reg <= velocities_in;
            snap_frc_reg <= forces_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= ST_IDLE;
            body_cnt_reg <= '0;
            node_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            body_cnt_reg <= body_cnt_next;
            node_cnt_reg <= node_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        body_cnt_next = body_cnt_reg;
        node_cnt_next = node_cnt_reg;
        issue_valid   = 1'b0;
        snap_load     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (begin_in) begin
                    snap_load     = 1'b1;
                    body_cnt_next = '0;
                    node_cnt_next = '0;
                    state_next    = ST_RUN;
                end
            end
            ST_RUN: begin
                issue_valid = 1'b1;
                if (node_cnt_reg == NW'(NUM_NODES - 1)) begin
                    node_cnt_next = '0;
                    if (body_cnt_reg == BW'(NUM_BODIES - 1)) begin
                        body_cnt_next = '0;
                        state_next    = ST_FLUSH;
                    end else begin
                        body_cnt_next = body_cnt_reg + BW'(1);
                    end
                end else begin
                    node_cnt_next = node_cnt_reg + NW'(1);
                end
            end
            // The last node is still in stage 1 while pipe_busy is high.
            ST_FLUSH: begin
                if (!pipe_busy) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_en = 1'b0;
        for (int b = 0; b < NUM_BODIES; b++) begin
            if (body_cnt_reg == BW'(b)) begin
                issue_en = mask_reg[b];
            end
        end
    end

    assign issue_idx = IW'(flat_index(int'(body_cnt_reg), int'(node_cnt_reg), NUM_NODES));

    euler_lane #(
        .POSITION_SIZE (POSITION_SIZE),
        .VELOCITY_SIZE (VELOCITY_SIZE),
        .FORCE_SIZE    (FORCE_SIZE),
        .DT            (DT),
        .GRAVITY       (GRAVITY),
        .MASS_SHIFT    (MASS_SHIFT),
        .DAMP_SHIFT    (DAMP_SHIFT),
        .TAG_W         (BW + NW)
    ) u_lane (
        .clk       (clk_in),
        .srst      (rst_in),
        .in_valid  (issue_valid),
        .enable    (issue_en),
        .tag_in    ({body_cnt_reg, node_cnt_reg}),
        .pos_x     (snap_pos_reg[0][issue_idx]),
        .pos_y     (snap_pos_reg[1][issue_idx]),
        .vel_x     (snap_vel_reg[0][issue_idx]),
        .vel_y     (snap_vel_reg[1][issue_idx]),
        .force_x   (snap_frc_reg[0][issue_idx]),
        .force_y   (snap_frc_reg[1][issue_idx]),
        .s1_valid  (pipe_busy),
        .out_valid (lane_valid),
        .tag_out   (lane_tag),
        .pos_x_out (node_out_x),
        .pos_y_out (node_out_y),
        .vel_x_out (velocity_out_x),
        .vel_y_out (velocity_out_y)
    );

    assign out_body           = lane_tag[BW+NW-1:NW];
    assign out_node           = lane_tag[NW-1:0];
    assign node_out_valid     = lane_valid;
    assign velocity_out_valid = lane_valid;
    assign busy_out           = (state_reg != ST_IDLE);
    assign result_out         = (state_reg == ST_DONE);

endmodule

// File: tb/tb_soft_body_integrator.sv
// Directed bench for soft_body_integrator: saturation, masking, latency, busy/begin rules, mid-run reset.
// Expected values account for SOFT_BODY_DAMPING_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_soft_body_integrator;

    localparam int NB  = 2;
    localparam int NN  = 4;
    localparam int TOT = NB * NN;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 begin_in;
    logic [NB-1:0]        body_mask;
    logic signed [16:0]   nodes_in      [2][TOT];
    logic signed [11:0]   velocities_in [2][TOT];
    logic signed [7:0]    forces_in     [2][TOT];
    logic                 busy_out;
    logic signed [16:0]   node_out_x, node_out_y;
    logic signed [11:0]   velocity_out_x, velocity_out_y;
    logic [1:0]           out_body;
    logic [2:0]           out_node;
    logic                 node_out_valid, velocity_out_valid, result_out;

    soft_body_integrator dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .begin_in           (begin_in),
        .body_mask          (body_mask),
        .nodes_in           (nodes_in),
        .velocities_in      (velocities_in),
        .forces_in          (forces_in),
        .busy_out           (busy_out),
        .node_out_x         (node_out_x),
        .node_out_y         (node_out_y),
        .velocity_out_x     (velocity_out_x),
        .velocity_out_y     (velocity_out_y),
        .out_body           (out_body),
        .out_node           (out_node),
        .node_out_valid     (node_out_valid),
        .velocity_out_valid (velocity_out_valid),
        .result_out         (result_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dmp(input int v);
`ifdef SOFT_BODY_DAMPING_EN
        return v - (v >>> 4);
`else
        return v;
`endif
    endfunction

    // Stimulus: body 0 is integrated, body 1 is masked off and must pass through.
    int s_px[TOT] = '{0, 65535, 100, -65536, 0, 10, 7, 30};
    int s_py[TOT] = '{0, 0, 50, 20, 0, -1, -3, -3};
    int s_vx[TOT] = '{0, 2047, 32, -10, 0, 1, 1, 3};
    int s_vy[TOT] = '{0, -2048, 0, 5, 0, -1, 1, -3};
    int s_fx[TOT] = '{4, 10, 0, -3, 9, 9, 50, 9};
    int s_fy[TOT] = '{0, -5, 1, 0, 9, 9, 50, 9};
    int e_px[TOT], e_py[TOT], e_vx[TOT], e_vy[TOT];

    logic signed [63:0] cap_body[TOT], cap_node[TOT], cap_px[TOT], cap_py[TOT], cap_vx[TOT], cap_vy[TOT];
    int n_valid, n_result, first_cyc, last_cyc, result_cyc, busy_at_result, busy_after;

    task automatic load_vectors();
        body_mask = 2'b01;
        for (int i = 0; i < TOT; i++) begin
            nodes_in[0][i]      = 17'(s_px[i]);
            nodes_in[1][i]      = 17'(s_py[i]);
            velocities_in[0][i] = 12'(s_vx[i]);
            velocities_in[1][i] = 12'(s_vy[i]);
            forces_in[0][i]     = 8'(s_fx[i]);
            forces_in[1][i]     = 8'(s_fy[i]);
        end
    endtask

    task automatic scramble_inputs();
        body_mask = 2'b10;
        for (int i = 0; i < TOT; i++) begin
            nodes_in[0][i]      = 17'sd1234;
            nodes_in[1][i]      = -17'sd999;
            velocities_in[0][i] = 12'sd77;
            velocities_in[1][i] = -12'sd55;
            forces_in[0][i]     = 8'sd100;
            forces_in[1][i]     = -8'sd100;
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_valid"}, node_out_valid, 0);
        check({name, "_vvalid"}, velocity_out_valid, 0);
        check({name, "_result"}, result_out, 0);
        check({name, "_busy"}, busy_out, 0);
        check({name, "_px"}, node_out_x, 0);
        check({name, "_vy"}, velocity_out_y, 0);
        check({name, "_body_node"}, {out_body, out_node}, 0);
    endtask

    // Inputs set at a negedge are sampled by the posedge ending that cycle; cycle 0 is the begin cycle.
    task automatic run_update(input int rebegin_cyc, input int reset_on_valid);
        bit rst_pending = 1'b0;
        bit rst_done    = 1'b0;
        n_valid = 0; n_result = 0; first_cyc = -1; last_cyc = -1;
        result_cyc = -1; busy_at_result = -1; busy_after = -1;
        for (int i = 0; i < TOT; i++) begin
            cap_body[i] = 'x; cap_node[i] = 'x; cap_px[i] = 'x;
            cap_py[i] = 'x; cap_vx[i] = 'x; cap_vy[i] = 'x;
        end
        @(negedge clk_in);
        begin_in = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk_in);
            if (rst_pending) begin
                check_zero_outputs("abort");
                rst_in = 1'b0;
                rst_pending = 1'b0;
            end
            if (c == 1) begin
                begin_in = 1'b0;
                check("busy_after_begin", busy_out, 1);
                scramble_inputs();
            end
            if (result_cyc > 0 && c == result_cyc + 1) busy_after = busy_out;
            if (node_out_valid) begin
                check($sformatf("vvalid_c%0d", c), velocity_out_valid, 1);
                if (n_valid < TOT) begin
                    cap_body[n_valid] = out_body;
                    cap_node[n_valid] = out_node;
                    cap_px[n_valid] = node_out_x;
                    cap_py[n_valid] = node_out_y;
                    cap_vx[n_valid] = velocity_out_x;
                    cap_vy[n_valid] = velocity_out_y;
                end
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                n_valid++;
            end
            if (result_out) begin
                n_result++;
                result_cyc = c;
                busy_at_result = busy_out;
            end
            if (rebegin_cyc > 0 && c == rebegin_cyc) begin_in = 1'b1;
            if (rebegin_cyc > 0 && c == rebegin_cyc + 1) begin_in = 1'b0;
            if (reset_on_valid > 0 && n_valid == reset_on_valid && !rst_done) begin
                rst_in = 1'b1;
                rst_pending = 1'b1;
                rst_done = 1'b1;
            end
        end
        begin_in = 1'b0;
        rst_in = 1'b0;
    endtask

    task automatic check_stream(input string name);
        check({name, "_count"}, n_valid, TOT);
        check({name, "_results"}, n_result, 1);
        check({name, "_first_cyc"}, first_cyc, 3);
        check({name, "_last_cyc"}, last_cyc, 10);
        check({name, "_result_cyc"}, result_cyc, 11);
        check({name, "_busy_at_result"}, busy_at_result, 1);
        check({name, "_busy_fall"}, busy_after, 0);
        for (int i = 0; i < TOT; i++) begin
            check($sformatf("%s_body[%0d]", name, i), cap_body[i], i / NN);
            check($sformatf("%s_node[%0d]", name, i), cap_node[i], i % NN);
            check($sformatf("%s_px[%0d]", name, i), cap_px[i], e_px[i]);
            check($sformatf("%s_py[%0d]", name, i), cap_py[i], e_py[i]);
            check($sformatf("%s_vx[%0d]", name, i), cap_vx[i], e_vx[i]);
            check($sformatf("%s_vy[%0d]", name, i), cap_vy[i], e_vy[i]);
        end
    endtask

    initial begin
        // Hand-worked body 0 results; body 1 is masked and echoes its snapshot.
        e_vx[0] = dmp(4);     e_vy[0] = dmp(-1);     e_px[0] = e_vx[0];        e_py[0] = e_vy[0];
        e_vx[1] = dmp(2047);  e_vy[1] = dmp(-2048);  e_px[1] = 65535;          e_py[1] = e_vy[1];
        e_vx[2] = dmp(32);    e_vy[2] = 0;           e_px[2] = 100 + e_vx[2];  e_py[2] = 50;
        e_vx[3] = dmp(-13);   e_vy[3] = dmp(4);      e_px[3] = -65536;         e_py[3] = 20 + e_vy[3];
        for (int i = NN; i < TOT; i++) begin
            e_px[i] = s_px[i]; e_py[i] = s_py[i]; e_vx[i] = s_vx[i]; e_vy[i] = s_vy[i];
        end

        rst_in = 1'b1;
        begin_in = 1'b0;
        load_vectors();
        repeat (3) @(negedge clk_in);
        check_zero_outputs("in_reset");
        rst_in = 1'b0;
        @(negedge clk_in);
        check_zero_outputs("after_reset");

        load_vectors();
        run_update(0, 0);
        check_stream("basic");

        load_vectors();
        run_update(2, 0);
        check_stream("rebegin_busy");

        load_vectors();
        run_update(11, 0);
        check_stream("begin_at_result");

        load_vectors();
        run_update(0, 3);
        check("abort_valids", n_valid, 3);
        check("abort_results", n_result, 0);

        load_vectors();
        run_update(0, 0);
        check_stream("post_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
